// File: rtl/reset_seq_wdt.sv
// reset_seq_wdt: staged reset release for NUM_DOMAINS domains once the PLL
// is locked, plus a windowed watchdog, per-domain software reset pulses and
// sticky reset-cause flags. Single clock domain (clk_sys).
module reset_seq_wdt #(
  parameter int                     NUM_DOMAINS  = 4,
  parameter int                     STAGE_DELAY  = 16,
  parameter int                     PULSE_CYCLES = 64,
  parameter int                     WDT_WIDTH    = 32,
  parameter logic [NUM_DOMAINS-1:0] PROTECT_MASK = NUM_DOMAINS'(1)
) (
  input  logic                   clk_sys,
  input  logic                   rst_sys_n,
  input  logic                   pll_locked,
  input  logic                   sw_sys_rst,
  input  logic [NUM_DOMAINS-1:0] sw_dom_rst,
  input  logic                   wdt_enable,
  input  logic [WDT_WIDTH-1:0]   wdt_timeout,
  input  logic [WDT_WIDTH-1:0]   wdt_window,
  input  logic                   wdt_kick,
  input  logic                   cause_clr,
  output logic [NUM_DOMAINS-1:0] dom_rst_n,
  output logic                   seq_done,
  output logic [WDT_WIDTH-1:0]   wdt_count,
  output logic                   wdt_fire,
  output logic [3:0]             rst_cause
);

  localparam int SCW = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
  localparam int PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN, S_PULSE} state_e;

  state_e                 state_q, state_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   seq_done_q, seq_done_d;
  logic [WDT_WIDTH-1:0]   count_q, count_d;
  logic                   fire_q, fire_d;
  logic [3:0]             cause_q, cause_d;
  logic [3:0]             cause_set;
  logic [SCW-1:0]         stage_q, stage_d;
  logic [PCW-1:0]         pulse_q, pulse_d;

  logic [NUM_DOMAINS-1:0] unprot;
  logic [NUM_DOMAINS-1:0] dom_req;
  logic [NUM_DOMAINS-1:0] next_rel;
  logic [NUM_DOMAINS-1:0] clr_mask;
  logic                   legal_kick;
  logic                   early_kick;
  logic                   timeout_hit;
  logic                   wdt_trig;

  // Watchdog event decode and helper masks (lowest still-asserted domain is next to release)
  always_comb begin
    unprot      = ~PROTECT_MASK;
    dom_req     = sw_dom_rst & unprot;
    next_rel    = ~dom_q & (dom_q + NUM_DOMAINS'(1));
    legal_kick  = wdt_kick && ((wdt_window == '0) || (count_q >= wdt_window));
    early_kick  = wdt_kick && !legal_kick;
    timeout_hit = (wdt_timeout != '0) && (count_q == wdt_timeout) && !legal_kick;
    wdt_trig    = wdt_enable && (early_kick || timeout_hit);
    clr_mask    = dom_req | (sw_sys_rst ? unprot : '0);
  end

  // Next-state and output logic; PLL loss overrides everything at the end
  always_comb begin
    state_d   = state_q;
    dom_d     = dom_q;
    stage_d   = stage_q;
    pulse_d   = pulse_q;
    count_d   = '0;
    fire_d    = 1'b0;
    cause_set = 4'b0000;

    unique case (state_q)
      S_HOLD: begin
        dom_d = '0;
        if (pll_locked) begin
          state_d = S_RELEASE;
          stage_d = '0;
        end
      end
      S_RELEASE: begin
        if (&dom_q) begin
          state_d = S_RUN;
        end else if (stage_q == SCW'(STAGE_DELAY - 1)) begin
          dom_d   = dom_q | next_rel;
          stage_d = '0;
          if (&(dom_q | next_rel)) state_d = S_RUN;
        end else begin
          stage_d = stage_q + SCW'(1);
        end
      end
      S_RUN: begin
        if (wdt_enable) begin
          if (legal_kick)   count_d = '0;
          else if (&count_q) count_d = count_q;
          else              count_d = count_q + WDT_WIDTH'(1);
        end
        if (wdt_trig || sw_sys_rst) begin
          fire_d       = wdt_trig;
          cause_set[1] = wdt_enable && timeout_hit;
          cause_set[2] = wdt_enable && early_kick;
          cause_set[3] = sw_sys_rst;
          dom_d        = dom_q & PROTECT_MASK;
          state_d      = S_PULSE;
          pulse_d      = '0;
          count_d      = '0;
        end else if (|dom_req) begin
          dom_d   = dom_q & ~dom_req;
          state_d = S_PULSE;
          pulse_d = '0;
          count_d = '0;
        end
      end
      S_PULSE: begin
        if (|clr_mask) begin
          dom_d        = dom_q & ~clr_mask;
          pulse_d      = '0;
          cause_set[3] = sw_sys_rst;
        end else if (pulse_q == PCW'(PULSE_CYCLES - 1)) begin
          state_d = S_RELEASE;
          stage_d = '0;
        end else begin
          pulse_d = pulse_q + PCW'(1);
        end
      end
      default: state_d = S_HOLD;
    endcase

    if ((state_q != S_HOLD) && !pll_locked) begin
      state_d   = S_HOLD;
      dom_d     = '0;
      count_d   = '0;
      fire_d    = 1'b0;
      cause_set = 4'b0001;
    end

    seq_done_d = (state_q == S_RUN) && (state_d == S_RUN);
    cause_d    = (cause_clr ? 4'b0000 : cause_q) | cause_set;
  end

  // State and output registers, asynchronously cleared by rst_sys_n
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q    <= S_HOLD;
      dom_q      <= '0;
      seq_done_q <= 1'b0;
      count_q    <= '0;
      fire_q     <= 1'b0;
      cause_q    <= 4'b0000;
      stage_q    <= '0;
      pulse_q    <= '0;
    end else begin
      state_q    <= state_d;
      dom_q      <= dom_d;
      seq_done_q <= seq_done_d;
      count_q    <= count_d;
      fire_q     <= fire_d;
      cause_q    <= cause_d;
      stage_q    <= stage_d;
      pulse_q    <= pulse_d;
    end
  end

  assign dom_rst_n = dom_q;
  assign seq_done  = seq_done_q;
  assign wdt_count = count_q;
  assign wdt_fire  = fire_q;
  assign rst_cause = cause_q;

endmodule

// File: doc/reset_seq_wdt.md
Name: reset_seq_wdt

Overview:
- Parametrised successor to the clock/reset manager's reset and watchdog logic.
- Releases NUM_DOMAINS reset outputs in a fixed staged order once the PLL is locked.
- Provides a windowed watchdog, per-domain software reset pulses, and sticky reset-cause reporting.
- Sits in the clk_sys domain, downstream of the PLL; domain resets feed per-domain synchronizers elsewhere.

Parameters:
- NUM_DOMAINS, 4: number of reset outputs; domain 0 is released first.
- STAGE_DELAY, 16: clk_sys cycles between successive domain releases (>=1).
- PULSE_CYCLES, 64: reset assertion length for watchdog and software resets (>=1).
- WDT_WIDTH, 32: watchdog counter, timeout and window width.
- PROTECT_MASK, {NUM_DOMAINS{1'b0}} with bit0=1: domains immune to watchdog and software resets (debug domain).

Ports:
- clk_sys in 1: system clock.
- rst_sys_n in 1: asynchronous, active-low reset.
- pll_locked in 1: PLL lock, already synchronous to clk_sys.
- sw_sys_rst in 1: pulse; full re-sequence of all unprotected domains.
- sw_dom_rst in NUM_DOMAINS: pulse per domain; reset a single domain.
- wdt_enable in 1: watchdog enable (level).
- wdt_timeout in WDT_WIDTH: fire count; 0 = never fire.
- wdt_window in WDT_WIDTH: earliest legal kick count; 0 = no window.
- wdt_kick in 1: kick pulse.
- cause_clr in 1: clear rst_cause.
- dom_rst_n out NUM_DOMAINS: per-domain reset, active low.
- seq_done out 1: all domains released.
- wdt_count out WDT_WIDTH: current watchdog count.
- wdt_fire out 1: 1-cycle pulse on a watchdog trigger.
- rst_cause out 4: sticky causes; [0] PLL loss, [1] timeout, [2] early kick, [3] software system reset.

Behaviour:
- Reset values: dom_rst_n all 0; seq_done 0; wdt_count 0; wdt_fire 0; rst_cause 0; FSM in HOLD.
- States are HOLD, RELEASE, RUN and PULSE.
- HOLD:
  - All dom_rst_n are 0.
  - When pll_locked=1, go to RELEASE next cycle with idx=0 and stage counter 0.
- RELEASE:
  - The stage counter increments each cycle.
  - At count STAGE_DELAY-1: dom_rst_n[idx] goes to 1, the counter clears and idx increments.
  - Domain k deasserts exactly (k+1)*STAGE_DELAY cycles after RELEASE entry.
  - Domains already released, or protected and still released, are skipped without delay.
  - After the last domain: go to RUN; seq_done=1 on the following cycle.
- RUN:
  - The watchdog counts when wdt_enable=1 and saturates at all-ones.
  - Legal kick (wdt_window=0 or wdt_count>=wdt_window): wdt_count goes to 0.
  - Early kick (wdt_count<wdt_window): trigger, set cause[2].
  - wdt_count==wdt_timeout with wdt_timeout!=0 and no legal kick that cycle: trigger, set cause[1]. A legal kick beats a timeout in the same cycle.
  - Trigger effects: wdt_fire=1 for one cycle; unprotected domains asserted; seq_done=0; go to PULSE.
  - sw_sys_rst: same as a trigger but sets cause[3]; wdt_fire stays 0.
  - sw_dom_rst[i] for an unprotected domain: that domain is asserted and the FSM goes to PULSE with pulse mask = the requested bits. Requests on protected bits are ignored.
- PULSE:
  - Masked domains are held at 0 for PULSE_CYCLES.
  - Requests arriving during PULSE are OR-ed into the mask and restart the pulse counter.
  - At expiry go to RELEASE with idx=0. Only asserted domains are re-released, in order.
- Watchdog outside RUN: wdt_count is held at 0; kicks are ignored.
- wdt_enable falling: wdt_count clears.
- PLL loss: pll_locked=0 in any non-HOLD state.
  - All domains, including protected ones, go to 0 next cycle; seq_done=0; set cause[0]; go to HOLD.
  - PLL loss has priority over every other event.
- rst_cause:
  - Bits are set-only, independent of dom_rst_n, and cleared only by cause_clr or rst_sys_n.
  - A set and cause_clr in the same cycle leaves the bit set.
- rst_sys_n asserted mid-operation returns everything to reset values immediately (asynchronously).

Test Plan:
- Power-up: NUM_DOMAINS=4, STAGE_DELAY=16; pll_locked rises at cycle 10 -> dom_rst_n goes 0001,0011,0111,1111 at 16, 32, 48 and 64 cycles after RELEASE entry; seq_done=1 one cycle after the last release.
- Timeout: timeout=100, window=0, no kicks -> wdt_fire pulses at count 100; rst_cause=0010; dom_rst_n=0001 for 64 cycles; then domains 1-3 re-release at 16-cycle steps.
- Window: window=50, timeout=200 -> kick at count 60 clears the count with no reset; kick at count 20 -> rst_cause[2]=1 and wdt_fire pulse.
- Simultaneous: legal kick exactly at count==timeout -> no fire, count goes to 0.
- Software domain reset: sw_dom_rst=0100 in RUN -> only domain 2 is low for 64 cycles; a second request 0010 at pulse cycle 30 extends both domains by 64 cycles from that point; sw_dom_rst=0001 -> ignored.
- PLL loss: drop pll_locked mid-PULSE -> dom_rst_n=0000 next cycle and rst_cause[0]=1; relock re-sequences all four domains; cause_clr -> rst_cause=0000.
